uart_tx_serializer: RTL and testbench

//  Transmit half of the full-duplex UART. Consumes the square-wave baud_clk from the TX baud generator.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tick_detect.sv | 30 +++
 rtl/uart_tx_serializer.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types for the UART transmit path.
//   - tx_state_t  : serializer FSM state encoding
//   - frame_cfg_t : per-frame line configuration, captured with each byte
//   - parity_bit(): parity bit from the XOR-reduction of the data bits
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic stop2;
    } frame_cfg_t;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;

    // xor_all is ^data; even parity repeats it, odd parity inverts it.
    function automatic logic parity_bit(input logic xor_all, input logic odd);
        return xor_all ^ odd;
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// -----------------------------------------------------------------------------
// uart_tick_detect
//   Rising-edge detector for a square-wave rate clock generated in the clk
//   domain (no synchroniser needed). Also usable by the RX side on a 16x clock.
// Ports
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   i_level  in   square wave to watch
//   o_tick   out  one-clk pulse in the cycle i_level is first seen high
// -----------------------------------------------------------------------------
module uart_tick_detect (
    input  logic clk,
    input  logic rstn,
    input  logic i_level,
    output logic o_tick
);

    logic r_level_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_tick = i_level & ~r_level_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit serializer. Bytes arrive over a valid/ready handshake into a
//   one-entry holding register and are shifted out LSB first as
//   start, DATA_BITS data, optional parity, 1 or 2 stop bits. Every line change
//   happens on a rising edge of i_baud_clk, so back-to-back frames have no gap.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | line high, waiting for a tick with the holding register full
//   START  | start bit (low) on the line
//   DATA   | data bit r_bit_cnt on the line, r_shift[0] is the current bit
//   PARITY | parity bit on the line
//   STOP   | stop bit r_stop_cnt on the line
//
// Parameters
//   DATA_BITS     data bits per frame, legal 5..9
// Ports
//   clk           in   system clock, sole domain
//   rstn          in   asynchronous active-low reset
//   i_baud_clk    in   baud square wave from the TX baud generator (clk domain)
//   i_tx_data     in   data word to send
//   i_tx_valid    in   data and config inputs valid
//   i_parity_en   in   parity bit present
//   i_parity_odd  in   odd (1) / even (0) parity
//   i_stop2       in   two stop bits (1) / one (0)
//   o_tx_ready    out  holding register empty
//   o_tx          out  serial line, idle high
//   o_tx_busy     out  frame on the line or pending
//   o_tx_done     out  one-clk pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_baud_clk,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_stop2,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int unsigned          CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_BITS - 1);

    // Assertion is asynchronous; release is retimed so no flop sees a
    // reset removal close to a clock edge.
    logic [1:0]           r_rst_sync;
    logic                 w_rstn;

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_hold_xor;

    logic [DATA_BITS-1:0] r_hold_data;
    frame_cfg_t           r_hold_cfg;
    logic                 r_hold_full;

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    frame_cfg_t           r_cfg;
    logic                 r_xor;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rstn = r_rst_sync[1];

    uart_tick_detect u_tick_detect (
        .clk     (clk),
        .rstn    (w_rstn),
        .i_level (i_baud_clk),
        .o_tick  (w_tick)
    );

    assign w_accept   = i_tx_valid & ~r_hold_full;
    assign w_hold_xor = ^r_hold_data;

    // Holding register, shifter, counters and FSM share one block so the
    // holding-register handoff (fill on accept, drain on load) has one driver.
    // Accept and load are mutually exclusive: accept needs the register empty,
    // load needs it full.
    always_ff @(posedge clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_hold_data <= '0;
            r_hold_cfg  <= '0;
            r_hold_full <= 1'b0;
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cfg       <= '0;
            r_xor       <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_hold_data <= i_tx_data;
                r_hold_cfg  <= {i_parity_en, i_parity_odd, i_stop2};
                r_hold_full <= 1'b1;
            end

            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (r_hold_full) begin
                            r_shift     <= r_hold_data;
                            r_cfg       <= r_hold_cfg;
                            r_xor       <= w_hold_xor;
                            r_hold_full <= 1'b0;
                            r_tx        <= 1'b0;
                            r_state     <= START;
                        end
                    end

                    START: begin
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end

                    DATA: begin
                        if (r_bit_cnt != LAST_BIT) begin
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            r_tx      <= r_shift[1];
                        end else if (r_cfg.parity_en) begin
                            r_tx    <= parity_bit(r_xor, r_cfg.parity_odd);
                            r_state <= PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= STOP;
                        end
                    end

                    PARITY: begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= STOP;
                    end

                    STOP: begin
                        if (r_cfg.stop2 && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            if (r_hold_full) begin
                                // Next frame's start bit replaces the idle bit.
                                r_shift     <= r_hold_data;
                                r_cfg       <= r_hold_cfg;
                                r_xor       <= w_hold_xor;
                                r_hold_full <= 1'b0;
                                r_tx        <= 1'b0;
                                r_state     <= START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end

                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx       = r_tx;
    assign o_tx_done  = r_done;
    assign o_tx_ready = ~r_hold_full;
    assign o_tx_busy  = (r_state != IDLE) | r_hold_full;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    typedef struct {
        logic [15:0] bits;   // LSB first: start, data, [parity], stop(s)
        int          nbits;
        bit          b2b;    // must start on the tick right after the previous frame
    } frame_t;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       baud_clk = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       valid8   = 1'b0;
    logic       valid7   = 1'b0;
    logic       pen      = 1'b0;
    logic       podd     = 1'b0;
    logic       s2       = 1'b0;

    logic rdy8, tx8, busy8, done8;
    logic rdy7, tx7, busy7, done7;

    bit   baud_run = 1'b1;
    bit   mon_sel  = 1'b0;
    logic mon_tx, mon_done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    frame_t sb_q[$];
    bit     in_frame  = 1'b0;
    bit     exp_done  = 1'b0;
    bit     mon_abort = 1'b0;
    int     mon_idx   = 0;

    uart_tx_serializer #(.DATA_BITS(8)) u_dut8 (
        .clk          (clk),
        .rstn         (rstn),
        .i_baud_clk   (baud_clk),
        .i_tx_data    (tx_data),
        .i_tx_valid   (valid8),
        .i_parity_en  (pen),
        .i_parity_odd (podd),
        .i_stop2      (s2),
        .o_tx_ready   (rdy8),
        .o_tx         (tx8),
        .o_tx_busy    (busy8),
        .o_tx_done    (done8)
    );

    uart_tx_serializer #(.DATA_BITS(7)) u_dut7 (
        .clk          (clk),
        .rstn         (rstn),
        .i_baud_clk   (baud_clk),
        .i_tx_data    (tx_data[6:0]),
        .i_tx_valid   (valid7),
        .i_parity_en  (pen),
        .i_parity_odd (podd),
        .i_stop2      (s2),
        .o_tx_ready   (rdy7),
        .o_tx         (tx7),
        .o_tx_busy    (busy7),
        .o_tx_done    (done7)
    );

    assign mon_tx   = mon_sel ? tx7   : tx8;
    assign mon_done = mon_sel ? done7 : done8;

    always #10 clk = ~clk;

    // Baud square wave: 8 clk high, 8 clk low; changes on negedge clk.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (baud_run) begin
                if (cnt == 7) begin
                    cnt = 0;
                    baud_clk = ~baud_clk;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one sample per bit, one clk after each baud rising edge.
    initial begin
        frame_t cur;
        logic   s_tx, s_done;
        bit     ended;
        forever begin
            @(posedge baud_clk);
            @(posedge clk);
            #1;
            s_tx   = mon_tx;
            s_done = mon_done;
            if (mon_abort) begin
                sb_q.delete();
                in_frame  = 1'b0;
                exp_done  = 1'b0;
                mon_idx   = 0;
                mon_abort = 1'b0;
            end else begin
                check("done_timing", s_done, exp_done);
                ended    = exp_done;
                exp_done = 1'b0;
                if (!in_frame) begin
                    if (sb_q.size() != 0 && (s_tx == 1'b0 || (ended && sb_q[0].b2b))) begin
                        cur      = sb_q.pop_front();
                        mon_idx  = 0;
                        in_frame = 1'b1;
                    end else if (sb_q.size() == 0) begin
                        check("idle_line", s_tx, 1'b1);
                    end
                end
                if (in_frame) begin
                    check($sformatf("frame_bit%0d", mon_idx), s_tx, cur.bits[mon_idx]);
                    mon_idx++;
                    if (mon_idx == cur.nbits) begin
                        in_frame = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_done) done_cnt++;
        end
    end

    task automatic send(input bit sel7, input logic [7:0] d, input bit p_en, input bit p_odd,
                        input bit st2, input logic [15:0] bits, input int nb, input bit b2b,
                        input bit align);
        frame_t f;
        int     n;
        if (align) @(posedge baud_clk);
        else       @(negedge clk);
        tx_data = d;
        pen     = p_en;
        podd    = p_odd;
        s2      = st2;
        if (sel7) valid7 = 1'b1;
        else      valid8 = 1'b1;
        n = 0;
        while (!(sel7 ? rdy7 : rdy8) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 2000, 1);
        @(posedge clk);
        f.bits  = bits;
        f.nbits = nb;
        f.b2b   = b2b;
        sb_q.push_back(f);
        if (align) begin
            #1;
            check("same_tick_no_start", mon_tx, 1'b1);
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        valid8 = 1'b0;
        valid7 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || in_frame || exp_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain", n < 20000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bit(input int idx);
        int n = 0;
        while (!(in_frame && mon_idx == idx) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_bit", n < 5000, 1);
    endtask

    initial begin
        int d0;
        int bad;
        logic tx0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_tx", tx8, 1'b1);
        check("rst_ready", rdy8, 1'b1);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xA5 8N1
        d0 = done_cnt;
        send(0, 8'hA5, 0, 0, 0, 16'h034A, 10, 0, 0);
        release_valid();
        wait_idle();
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_ready", rdy8, 1'b1);
        check("t1_busy", busy8, 1'b0);

        // 2: parity and stop variants; first one accepted on a tick edge
        d0 = done_cnt;
        send(0, 8'hA5, 1, 0, 0, 16'h054A, 11, 0, 1);
        release_valid();
        wait_idle();
        send(0, 8'hA5, 1, 1, 0, 16'h074A, 11, 0, 0);
        release_valid();
        wait_idle();
        send(0, 8'hA5, 1, 0, 1, 16'h0D4A, 12, 0, 0);
        release_valid();
        wait_idle();
        check("t2_done_count", done_cnt - d0, 3);

        // 3: back-to-back with tx_valid held; third word stalls
        d0 = done_cnt;
        send(0, 8'h00, 0, 0, 0, 16'h0200, 10, 0, 0);
        send(0, 8'hFF, 0, 0, 0, 16'h03FE, 10, 1, 0);
        @(negedge clk);
        check("t3_stall_ready", rdy8, 1'b0);
        check("t3_stall_busy", busy8, 1'b1);
        send(0, 8'h3C, 0, 0, 0, 16'h0278, 10, 1, 0);
        release_valid();
        wait_idle();
        check("t3_done_count", done_cnt - d0, 3);

        // 4: reset in the middle of data bit 4
        send(0, 8'hC3, 0, 0, 0, 16'h0386, 10, 0, 0);
        release_valid();
        wait_bit(6);
        repeat (3) @(negedge clk);
        rstn      = 1'b0;
        mon_abort = 1'b1;
        #1;
        check("t4_rst_tx", tx8, 1'b1);
        check("t4_rst_ready", rdy8, 1'b1);
        check("t4_rst_busy", busy8, 1'b0);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        begin
            int n = 0;
            while (mon_abort && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("t4_flush", n < 1000, 1);
        end
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        send(0, 8'h5A, 0, 0, 0, 16'h02B4, 10, 0, 0);
        release_valid();
        wait_idle();
        check("t4_done_count", done_cnt - d0, 1);

        // 5: baud frozen mid-frame
        d0 = done_cnt;
        send(0, 8'h96, 0, 0, 0, 16'h032C, 10, 0, 0);
        release_valid();
        wait_bit(4);
        repeat (5) @(negedge clk);
        baud_run = 1'b0;
        tx0 = tx8;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx8 !== tx0 || done8 !== 1'b0 || busy8 !== 1'b1) bad++;
        end
        check("t5_freeze_stable", bad, 0);
        baud_run = 1'b1;
        wait_idle();
        check("t5_done_count", done_cnt - d0, 1);

        // 6: DATA_BITS=7, 0x55, odd parity
        mon_sel = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        send(1, 8'h55, 1, 1, 0, 16'h03AA, 10, 0, 0);
        release_valid();
        wait_idle();
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_ready", rdy7, 1'b1);
        check("t6_busy", busy7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
